// File: rtl/pulse_interval_meter.sv
// Pulse interval meter.
// Counts count_en ticks between successive pulse_in strobes. Measurement is
// back-to-back, so the strobe that closes one interval also opens the next.
// Each completed interval goes to a single-entry valid/ready output register.
// When that register is still holding an unaccepted result, the new result is
// discarded and a one-cycle dropped pulse is raised.
module pulse_interval_meter #(
  parameter int W = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         arm,
  input  logic         count_en,
  input  logic         pulse_in,
  output logic [W-1:0] meas_value,
  output logic         meas_ovf,
  output logic         meas_valid,
  input  logic         meas_ready,
  output logic         dropped
);

  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t       state_r;
  state_t       state_nxt_s;
  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_nxt_s;
  logic         cnt_ovf_r;
  logic         cnt_ovf_nxt_s;

  logic         ev_s;
  logic         done_s;
  logic [W:0]   sum_s;
  logic         res_ovf_s;
  logic [W-1:0] res_value_s;

  logic [W-1:0] meas_value_r;
  logic         meas_ovf_r;
  logic         meas_valid_r;
  logic         dropped_r;

  // Every sampled-high pulse_in is an event; a held level counts once per cycle.
  assign ev_s = pulse_in;

  // Closing value: the end-cycle tick is included. The sum is one bit wider so
  // that a carry out of the W-bit counter shows up as saturation.
  assign sum_s       = {1'b0, cnt_r} + {{W{1'b0}}, count_en};
  assign res_ovf_s   = cnt_ovf_r | sum_s[W];
  assign res_value_s = res_ovf_s ? CNT_MAX : sum_s[W-1:0];

  // Holds the FSM state and the saturating interval counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      cnt_ovf_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      cnt_ovf_r <= cnt_ovf_nxt_s;
    end
  end

  // Computes the next state and counter, and flags a completed interval.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    cnt_ovf_nxt_s = cnt_ovf_r;
    done_s        = 1'b0;
    case (state_r)
      IDLE: begin
        // The start cycle's tick is deliberately not counted.
        cnt_nxt_s     = CNT_ZERO;
        cnt_ovf_nxt_s = 1'b0;
        if (arm && ev_s) begin
          state_nxt_s = MEASURE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MEASURE: begin
        if (!arm) begin
          state_nxt_s   = IDLE;
          cnt_nxt_s     = CNT_ZERO;
          cnt_ovf_nxt_s = 1'b0;
        end else if (ev_s) begin
          // Closing strobe reopens the next interval straight away.
          done_s        = 1'b1;
          state_nxt_s   = MEASURE;
          cnt_nxt_s     = CNT_ZERO;
          cnt_ovf_nxt_s = 1'b0;
        end else if (count_en) begin
          if (cnt_r == CNT_MAX) begin
            cnt_nxt_s     = CNT_MAX;
            cnt_ovf_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s     = cnt_r + CNT_ONE;
            cnt_ovf_nxt_s = cnt_ovf_r;
          end
        end else begin
          cnt_nxt_s     = cnt_r;
          cnt_ovf_nxt_s = cnt_ovf_r;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        cnt_nxt_s     = CNT_ZERO;
        cnt_ovf_nxt_s = 1'b0;
      end
    endcase
  end

  // Single-entry output register. It loads when empty or being drained,
  // otherwise it discards the new result and pulses dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      meas_value_r <= CNT_ZERO;
      meas_ovf_r   <= 1'b0;
      meas_valid_r <= 1'b0;
      dropped_r    <= 1'b0;
    end else begin
      dropped_r <= 1'b0;
      if (done_s) begin
        if (!meas_valid_r || meas_ready) begin
          meas_value_r <= res_value_s;
          meas_ovf_r   <= res_ovf_s;
          meas_valid_r <= 1'b1;
        end else begin
          dropped_r <= 1'b1;
        end
      end else if (meas_valid_r && meas_ready) begin
        meas_valid_r <= 1'b0;
      end else begin
        meas_valid_r <= meas_valid_r;
      end
    end
  end

  assign meas_value = meas_value_r;
  assign meas_ovf   = meas_ovf_r;
  assign meas_valid = meas_valid_r;
  assign dropped    = dropped_r;

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Self-checking bench for pulse_interval_meter.
// A W=9 and a W=4 instance share the same stimulus. Table vectors measure
// single intervals under several count_en patterns. Hand sequences cover
// reset, back-to-back strobes, the full/drop path, disarm and reset mid-run.
module tb_pulse_interval_meter;

  logic       clock;
  logic       reset;
  logic       arm;
  logic       count_en;
  logic       pulse_in;
  logic       meas_ready;
  logic [8:0] a_value;
  logic       a_ovf;
  logic       a_valid;
  logic       a_dropped;
  logic [3:0] b_value;
  logic       b_ovf;
  logic       b_valid;
  logic       b_dropped;

  int n_checks;
  int n_fail;

  pulse_interval_meter #(.W(9)) dut_a (
    .clock      (clock),
    .reset      (reset),
    .arm        (arm),
    .count_en   (count_en),
    .pulse_in   (pulse_in),
    .meas_value (a_value),
    .meas_ovf   (a_ovf),
    .meas_valid (a_valid),
    .meas_ready (meas_ready),
    .dropped    (a_dropped)
  );

  pulse_interval_meter #(.W(4)) dut_b (
    .clock      (clock),
    .reset      (reset),
    .arm        (arm),
    .count_en   (count_en),
    .pulse_in   (pulse_in),
    .meas_value (b_value),
    .meas_ovf   (b_ovf),
    .meas_valid (b_valid),
    .meas_ready (meas_ready),
    .dropped    (b_dropped)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int quiet;   // cycles strictly between opening and closing strobe
    int mode;    // count_en pattern: 0 always, 1 odd cycles, 2 even cycles
    int a_val;
    bit a_ovf;
    int b_val;
    bit b_ovf;
  } vec_t;

  vec_t vecs[10];

  function automatic logic ce_of(input int mode, input int i);
    if (mode == 1) return (i % 2) == 1;
    if (mode == 2) return (i % 2) == 0;
    return 1'b1;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs (called at a falling edge), then move to the
  // next falling edge so registered outputs of that cycle can be sampled.
  task automatic step(input logic r, input logic a, input logic ce,
                      input logic p, input logic rdy);
    reset      = r;
    arm        = a;
    count_en   = ce;
    pulse_in   = p;
    meas_ready = rdy;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Assuming MEASURE, run 'quiet' idle cycles then a closing strobe.
  task automatic run_interval(input int quiet, input int mode,
                              input logic rdy_q, input logic rdy_end);
    for (int i = 1; i <= quiet; i++) step(1'b0, 1'b1, ce_of(mode, i), 1'b0, rdy_q);
    step(1'b0, 1'b1, ce_of(mode, quiet + 1), 1'b1, rdy_end);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{9,  0, 10, 1'b0, 10, 1'b0};
    vecs[1] = '{14, 0, 15, 1'b0, 15, 1'b0};
    vecs[2] = '{15, 0, 16, 1'b0, 15, 1'b1};
    vecs[3] = '{19, 0, 20, 1'b0, 15, 1'b1};
    vecs[4] = '{19, 1, 10, 1'b0, 10, 1'b0};
    vecs[5] = '{19, 2, 10, 1'b0, 10, 1'b0};
    vecs[6] = '{0,  0, 1,  1'b0, 1,  1'b0};
    vecs[7] = '{0,  1, 1,  1'b0, 1,  1'b0};
    vecs[8] = '{0,  2, 0,  1'b0, 0,  1'b0};
    vecs[9] = '{29, 1, 15, 1'b0, 15, 1'b0};

    // Reset held two cycles with strobes and arm high: nothing may appear.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      cmp("rst_valid", int'(a_valid), 0);
      cmp("rst_value", int'(a_value), 0);
      cmp("rst_dropped", int'(a_dropped), 0);
    end
    // First strobe after reset only opens a measurement.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cmp("post_rst_start_valid", int'(a_valid), 0);

    // Table vectors: each starts from IDLE and measures one interval.
    for (int v = 0; v < 10; v++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, ce_of(vecs[v].mode, 0), 1'b1, 1'b1);
      cmp($sformatf("vec%0d_start_valid", v), int'(a_valid), 0);
      run_interval(vecs[v].quiet, vecs[v].mode, 1'b1, 1'b1);
      cmp($sformatf("vec%0d_a_valid", v), int'(a_valid), 1);
      cmp($sformatf("vec%0d_a_value", v), int'(a_value), vecs[v].a_val);
      cmp($sformatf("vec%0d_a_ovf", v), int'(a_ovf), int'(vecs[v].a_ovf));
      cmp($sformatf("vec%0d_b_value", v), int'(b_value), vecs[v].b_val);
      cmp($sformatf("vec%0d_b_ovf", v), int'(b_ovf), int'(vecs[v].b_ovf));
      cmp($sformatf("vec%0d_dropped", v), int'(a_dropped), 0);
    end

    // Back-to-back strobes at cycles 0, 10, 25.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cmp("b2b_start_valid", int'(a_valid), 0);
    run_interval(9, 0, 1'b1, 1'b1);
    cmp("b2b_first_valid", int'(a_valid), 1);
    cmp("b2b_first_value", int'(a_value), 10);
    run_interval(14, 0, 1'b1, 1'b1);
    cmp("b2b_second_valid", int'(a_valid), 1);
    cmp("b2b_second_value", int'(a_value), 15);

    // Saturation then recovery on the narrow instance: strobes at 0, 20, 25.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    run_interval(19, 0, 1'b1, 1'b1);
    cmp("sat_b_value", int'(b_value), 15);
    cmp("sat_b_ovf", int'(b_ovf), 1);
    cmp("sat_a_value", int'(a_value), 20);
    run_interval(4, 0, 1'b1, 1'b1);
    cmp("rec_b_value", int'(b_value), 5);
    cmp("rec_b_ovf", int'(b_ovf), 0);
    cmp("rec_a_value", int'(a_value), 5);

    // Full output: strobes at 0, 5, 12 with ready low, then 20 with ready.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    run_interval(4, 0, 1'b0, 1'b0);
    cmp("full_valid", int'(a_valid), 1);
    cmp("full_value", int'(a_value), 5);
    cmp("full_no_drop", int'(a_dropped), 0);
    run_interval(6, 0, 1'b0, 1'b0);
    cmp("drop_pulse", int'(a_dropped), 1);
    cmp("drop_value_kept", int'(a_value), 5);
    cmp("drop_valid_kept", int'(a_valid), 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cmp("drop_one_cycle", int'(a_dropped), 0);
    cmp("drop_value_still", int'(a_value), 5);
    run_interval(6, 0, 1'b0, 1'b1);
    cmp("accept_load_valid", int'(a_valid), 1);
    cmp("accept_load_value", int'(a_value), 8);
    cmp("accept_load_drop", int'(a_dropped), 0);

    // Disarm mid-measurement: strobe 0, arm low at 4, strobes 8 and 11.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 5; i <= 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    cmp("disarm_no_result", int'(a_valid), 0);
    run_interval(2, 0, 1'b1, 1'b0);
    cmp("rearm_valid", int'(a_valid), 1);
    cmp("rearm_value", int'(a_value), 3);

    // Reset six cycles into a measurement, with a result still pending.
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cmp("pending_before_rst", int'(a_valid), 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cmp("midrst_valid", int'(a_valid), 0);
    cmp("midrst_value", int'(a_value), 0);
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cmp("midrst_first_ev", int'(a_valid), 0);
    run_interval(3, 0, 1'b0, 1'b0);
    cmp("midrst_next_valid", int'(a_valid), 1);
    cmp("midrst_next_value", int'(a_value), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
